// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Tag width follows from the line count: 28 block-address bits minus the index bits.
package icache_pkg;
    localparam int          DEFAULT_LINES = 8;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    function automatic int tag_width(input int lines);
        return 28 - $clog2(lines);
    endfunction
endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read, write at posedge, valid bits cleared by reset or i_clear.
// No backpressure; a write on the same edge as i_clear leaves the written line valid.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = tag_width(LINES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [TW-1:0] i_wtag,
    input  logic [127:0]  i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic          o_valid,
    output logic [TW-1:0] o_tag,
    output logic [127:0]  o_data
);
    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [127:0]     r_data [LINES];

    // The later assignment lets a refill survive a coincident invalidate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            if (i_clear)
                r_valid <= '0;
            if (i_we)
                r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/icache_controller.sv
// Direct-mapped I-cache: hits return in 0 cycles; a miss stalls via busywait for
// 1 + memory busy time + 1 cycles while the block is fetched over the mem_read handshake.
module icache_controller
    import icache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  address,
    input  logic         invalidate,
    output logic [31:0]  readinst,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = tag_width(LINES);

    state_t         r_state;
    state_t         w_next;
    logic           r_seen_busy;
    logic [127:0]   r_block;
    logic           w_busywait;
    logic           w_mem_read;
    logic           w_hit;
    logic           w_line_valid;
    logic [TW-1:0]  w_line_tag;
    logic [127:0]   w_line_data;
    logic [IW-1:0]  w_idx;
    logic [TW-1:0]  w_tag;
    logic [1:0]     w_word;
    logic [31:0]    w_sel;
    logic           w_unused_low;

    assign w_idx        = address[3+IW:4];
    assign w_tag        = address[31:4+IW];
    assign w_word       = address[3:2];
    assign w_unused_low = ^address[1:0];

    icache_line_store #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_store (
        .clock   (clock),
        .reset   (reset),
        .i_clear (invalidate),
        .i_we    (r_state == UPDATE),
        .i_widx  (w_idx),
        .i_wtag  (w_tag),
        .i_wdata (r_block),
        .i_ridx  (w_idx),
        .o_valid (w_line_valid),
        .o_tag   (w_line_tag),
        .o_data  (w_line_data)
    );

    assign w_hit = w_line_valid && (w_line_tag == w_tag);
    assign w_sel = w_line_data[{w_word, 5'b0} +: 32];

    always_comb begin
        w_next     = r_state;
        w_busywait = 1'b0;
        w_mem_read = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_hit) begin
                    w_busywait = 1'b1;
                    w_next     = MEM_READ;
                end
            end
            MEM_READ: begin
                w_busywait = 1'b1;
                w_mem_read = 1'b1;
                if (r_seen_busy && !mem_busywait)
                    w_next = UPDATE;
            end
            UPDATE: begin
                w_busywait = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Reset is folded in combinationally so the stall and read request drop the moment it asserts.
    assign busywait    = reset && w_busywait;
    assign mem_read    = reset && w_mem_read;
    assign mem_address = address[31:4];
    assign readinst    = (!reset || w_busywait) ? NOP_INST : w_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_seen_busy <= 1'b0;
            r_block     <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == UPDATE)
                r_seen_busy <= 1'b0;
            else if (r_state == MEM_READ && mem_busywait)
                r_seen_busy <= 1'b1;
            if (r_state == MEM_READ && w_next == UPDATE)
                r_block <= mem_readdata;
            if (r_state == IDLE) begin
                if (w_hit && hit_count != 32'hFFFF_FFFF)
                    hit_count <= hit_count + 32'd1;
                if (!w_hit && miss_count != 32'hFFFF_FFFF)
                    miss_count <= miss_count + 32'd1;
            end
        end
    end
endmodule
